// File: rtl/han_carlson_adder_pipe.sv
// Pipelined Han-Carlson adder/subtractor with valid/ready streaming.
// Stage 1 conditions operands and pairs bits into odd/even groups.
// Stage 2 holds the group prefix after the first half of the Kogge-Stone levels.
// Stage 3 finishes the prefix, resolves carries and registers Sum and the flags.
// One global enable stalls every stage together, so latency is fixed at 3.
module han_carlson_adder_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int HALF   = WIDTH / 2;
  localparam int LEVELS = $clog2(HALF);
  // Levels applied before the stage-2 register; the rest follow it.
  localparam int LV_S2  = (LEVELS + 1) / 2;

  generate
    if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_width_check
      $error("han_carlson_adder_pipe: WIDTH must be even and >= 4");
    end
  endgenerate

  genvar gi;

  logic en;
  logic v1_q, v2_q, v3_q;

  assign en        = ~v3_q | out_ready;
  // Ready is forced high while in reset; the valid bits are cleared anyway.
  assign in_ready  = en | ~rst_n;
  assign out_valid = v3_q;

  // ---------------- Stage 0: operand conditioning and pairing ----------------
  logic [WIDTH-1:0] bx_d, p_d, g_d;
  logic [HALF-1:0]  ge_d, gg_d, gp_d;
  logic             c0_d;

  assign bx_d = Sub ? ~B : B;
  assign c0_d = Sub ? ~Cin : Cin;
  assign p_d  = A ^ bx_d;
  assign g_d  = A & bx_d;

  generate
    for (gi = 0; gi < HALF; gi++) begin : g_pair
      assign gg_d[gi] = g_d[2*gi+1] | (p_d[2*gi+1] & g_d[2*gi]);
      assign gp_d[gi] = p_d[2*gi+1] & p_d[2*gi];
      // Only the even generates are needed later, for the odd ripple cells.
      assign ge_d[gi] = g_d[2*gi];
    end
  endgenerate

  // ---------------- Stage 1 registers ----------------
  logic [WIDTH-1:0] s1_p_q;
  logic [HALF-1:0]  s1_ge_q, s1_gg_q, s1_gp_q;
  logic             s1_c0_q, s1_sa_q, s1_sb_q;

  // ---------------- Stage 2 registers ----------------
  logic [WIDTH-1:0] s2_p_q;
  logic [HALF-1:0]  s2_ge_q, s2_gg_q, s2_gp_q;
  logic             s2_c0_q, s2_sa_q, s2_sb_q;

  // First group of Kogge-Stone levels; positions below the distance pass through.
  logic [HALF-1:0] s2_gg_d, s2_gp_d;
  always_comb begin
    s2_gg_d = s1_gg_q;
    s2_gp_d = s1_gp_q;
    for (int l = 0; l < LV_S2; l++) begin
      // Descending k so the lower operand still holds the previous level.
      for (int k = HALF - 1; k >= (1 << l); k--) begin
        s2_gg_d[k] = s2_gg_d[k] | (s2_gp_d[k] & s2_gg_d[k - (1 << l)]);
        s2_gp_d[k] = s2_gp_d[k] & s2_gp_d[k - (1 << l)];
      end
    end
  end

  // Remaining Kogge-Stone levels after the stage-2 register.
  logic [HALF-1:0] pf_g, pf_p;
  always_comb begin
    pf_g = s2_gg_q;
    pf_p = s2_gp_q;
    for (int l = LV_S2; l < LEVELS; l++) begin
      for (int k = HALF - 1; k >= (1 << l); k--) begin
        pf_g[k] = pf_g[k] | (pf_p[k] & pf_g[k - (1 << l)]);
        pf_p[k] = pf_p[k] & pf_p[k - (1 << l)];
      end
    end
  end

  // Even carries come straight from the group prefix; odd carries ripple one bit.
  logic [HALF:0]    c_ev;
  logic [HALF-1:0]  c_od;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  assign c_ev[0] = s2_c0_q;
  generate
    for (gi = 0; gi < HALF; gi++) begin : g_carry
      assign c_ev[gi+1]     = pf_g[gi] | (pf_p[gi] & s2_c0_q);
      assign c_od[gi]       = s2_ge_q[gi] | (s2_p_q[2*gi] & c_ev[gi]);
      assign sum_d[2*gi]    = s2_p_q[2*gi] ^ c_ev[gi];
      assign sum_d[2*gi+1]  = s2_p_q[2*gi+1] ^ c_od[gi];
    end
  endgenerate

  assign ovf_d = (s2_sa_q == s2_sb_q) && (sum_d[WIDTH-1] != s2_sa_q);

  // Stage valid bits: cleared by reset, shift together when the pipe advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (en) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // Stage 1 and 2 datapath registers; contents are don't-care when invalid.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_p_q  <= p_d;
      s1_ge_q <= ge_d;
      s1_gg_q <= gg_d;
      s1_gp_q <= gp_d;
      s1_c0_q <= c0_d;
      s1_sa_q <= A[WIDTH-1];
      s1_sb_q <= bx_d[WIDTH-1];
      s2_p_q  <= s1_p_q;
      s2_ge_q <= s1_ge_q;
      s2_gg_q <= s2_gg_d;
      s2_gp_q <= s2_gp_d;
      s2_c0_q <= s1_c0_q;
      s2_sa_q <= s1_sa_q;
      s2_sb_q <= s1_sb_q;
    end
  end

  // Stage 3 result registers, held stable while the output is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Sum  <= '0;
      Cout <= 1'b0;
      Ovf  <= 1'b0;
      Zero <= 1'b0;
    end else if (en) begin
      Sum  <= sum_d;
      Cout <= c_ev[HALF];
      Ovf  <= ovf_d;
      Zero <= ~|sum_d;
    end
  end

endmodule

// File: tb/tb_han_carlson_adder_pipe.sv
// Bench for han_carlson_adder_pipe: directed cases, random streaming,
// backpressure, mid-flight reset, and WIDTH=12 / WIDTH=4 instances.
module tb_han_carlson_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 32-bit instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] A, B, Sum;
  logic        Cin, Sub, Cout, Ovf, Zero;

  // 12-bit instance
  logic        in_valid12, in_ready12, out_valid12;
  logic [11:0] A12, B12, Sum12;
  logic        Cin12, Sub12, Cout12, Ovf12, Zero12;

  // 4-bit instance
  logic        in_valid4, in_ready4, out_valid4;
  logic [3:0]  A4, B4, Sum4;
  logic        Cin4, Sub4, Cout4, Ovf4, Zero4;

  han_carlson_adder_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(out_valid),
    .out_ready(out_ready), .Sum(Sum), .Cout(Cout), .Ovf(Ovf), .Zero(Zero)
  );

  han_carlson_adder_pipe #(.WIDTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid12), .in_ready(in_ready12),
    .A(A12), .B(B12), .Cin(Cin12), .Sub(Sub12), .out_valid(out_valid12),
    .out_ready(1'b1), .Sum(Sum12), .Cout(Cout12), .Ovf(Ovf12), .Zero(Zero12)
  );

  han_carlson_adder_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(A4), .B(B4), .Cin(Cin4), .Sub(Sub4), .out_valid(out_valid4),
    .out_ready(1'b1), .Sum(Sum4), .Cout(Cout4), .Ovf(Ovf4), .Zero(Zero4)
  );

  int n_vec = 0;
  int n_err = 0;

  // Expected results as {zero, ovf, cout, sum[31:0]}, in input order.
  logic [34:0] q32[$];
  logic [34:0] q12[$];
  logic [34:0] q4[$];

  bit          acc32;
  int          rx32;
  bit          hold_vld;
  logic [34:0] hold_data;

  // Reference: plain modular arithmetic on the conditioned operands.
  function automatic logic [34:0] ref_model(int w, logic [31:0] a, logic [31:0] b,
                                            logic cin, logic sub);
    logic [31:0] mask, am, bx, s;
    logic [32:0] full;
    logic        c0, co, ov, zr;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am   = a & mask;
    bx   = (sub ? ~b : b) & mask;
    c0   = sub ? ~cin : cin;
    full = {1'b0, am} + {1'b0, bx} + {32'd0, c0};
    s    = full[31:0] & mask;
    co   = full[w];
    ov   = (am[w-1] == bx[w-1]) && (s[w-1] != am[w-1]);
    zr   = (s == 32'd0);
    return {zr, ov, co, s};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, score transfers, return after the rise.
  task automatic tick();
    @(negedge clk);
    acc32 = 1'b0;
    if (rst_n) begin
      if (hold_vld) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_data", {29'd0, Zero, Ovf, Cout, Sum}, {29'd0, hold_data});
      end
      if (out_valid && !out_ready)
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      if (out_valid && out_ready) begin
        chk("spurious32", {63'd0, q32.size() != 0}, 64'd1);
        if (q32.size() != 0)
          chk("res32", {29'd0, Zero, Ovf, Cout, Sum}, {29'd0, q32.pop_front()});
        rx32++;
      end
      if (in_valid && in_ready) begin
        q32.push_back(ref_model(32, A, B, Cin, Sub));
        acc32 = 1'b1;
      end
      if (out_valid12) begin
        chk("spurious12", {63'd0, q12.size() != 0}, 64'd1);
        if (q12.size() != 0)
          chk("res12", {29'd0, Zero12, Ovf12, Cout12, 20'd0, Sum12}, {29'd0, q12.pop_front()});
      end
      if (in_valid12 && in_ready12)
        q12.push_back(ref_model(12, {20'd0, A12}, {20'd0, B12}, Cin12, Sub12));
      if (out_valid4) begin
        chk("spurious4", {63'd0, q4.size() != 0}, 64'd1);
        if (q4.size() != 0)
          chk("res4", {29'd0, Zero4, Ovf4, Cout4, 28'd0, Sum4}, {29'd0, q4.pop_front()});
      end
      if (in_valid4 && in_ready4)
        q4.push_back(ref_model(4, {28'd0, A4}, {28'd0, B4}, Cin4, Sub4));
      hold_vld  = out_valid && !out_ready;
      hold_data = {Zero, Ovf, Cout, Sum};
    end else begin
      q32.delete();
      q12.delete();
      q4.delete();
      hold_vld = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Single directed operation with latency and constant-result checks.
  task automatic send_check(string tag, logic [31:0] a, logic [31:0] b, logic cin,
                            logic sub, logic [31:0] es, logic ec, logic eo, logic ez);
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
    tick();
    chk({tag, "_accept"}, {63'd0, acc32}, 64'd1);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
    tick();
    chk({tag, "_lat2"}, {63'd0, out_valid}, 64'd0);
    tick();
    chk({tag, "_lat3"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_sum"}, {32'd0, Sum}, {32'd0, es});
    chk({tag, "_flags"}, {61'd0, Cout, Ovf, Zero}, {61'd0, ec, eo, ez});
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, cyc;
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    in_valid12 = 1'b0; A12 = '0; B12 = '0; Cin12 = 1'b0; Sub12 = 1'b0;
    in_valid4 = 1'b0; A4 = '0; B4 = '0; Cin4 = 1'b0; Sub4 = 1'b0;
    hold_vld = 1'b0; rx32 = 0;

    // Reset state
    repeat (3) tick();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_regs", {29'd0, Zero, Ovf, Cout, Sum}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed cases
    send_check("wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send_check("ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send_check("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    send_check("sub_brw", 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0);

    // Back-to-back stream of 100 random operands
    for (int i = 0; i < 103; i++) begin
      in_valid = (i < 100);
      A = $urandom; B = $urandom;
      Cin = 1'($urandom_range(0, 1)); Sub = 1'($urandom_range(0, 1));
      tick();
      if (i < 100) chk("stream_accept", {63'd0, acc32}, 64'd1);
      chk("stream_valid", {63'd0, out_valid}, {63'd0, (i >= 2 && i <= 101)});
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain", q32.size(), 64'd0);

    // Backpressure: 10 operands, out_ready low for 5 cycles mid-stream
    sent = 0; cyc = 0; rx32 = 0;
    A = $urandom; B = $urandom;
    Cin = 1'($urandom_range(0, 1)); Sub = 1'($urandom_range(0, 1));
    while ((sent < 10 || q32.size() != 0) && cyc < 60) begin
      in_valid  = (sent < 10);
      out_ready = !(cyc >= 5 && cyc < 10);
      tick();
      if (acc32) begin
        sent++;
        A = $urandom; B = $urandom;
        Cin = 1'($urandom_range(0, 1)); Sub = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_sent", sent, 64'd10);
    chk("bp_received", rx32, 64'd10);
    chk("bp_drain", q32.size(), 64'd0);

    // Reset mid-flight: two operands in flight are discarded
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; A = $urandom; B = $urandom;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_sum", {32'd0, Sum}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_stale", {63'd0, out_valid}, 64'd0);
    end

    // WIDTH=12 random and WIDTH=4 exhaustive, streamed concurrently
    for (int i = 0; i < 10000; i++) begin
      logic [9:0] idx;
      idx = 10'(i);
      in_valid12 = 1'b1;
      A12 = 12'($urandom); B12 = 12'($urandom);
      Cin12 = 1'($urandom_range(0, 1)); Sub12 = 1'($urandom_range(0, 1));
      in_valid4 = (i < 1024);
      A4 = idx[3:0]; B4 = idx[7:4]; Cin4 = idx[8]; Sub4 = idx[9];
      tick();
    end
    in_valid12 = 1'b0; in_valid4 = 1'b0;
    repeat (5) tick();
    chk("w12_drain", q12.size(), 64'd0);
    chk("w4_drain", q4.size(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
